// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - pushbutton debouncer with press/release strobes and optional auto-repeat
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  // stable_cnt holds the number of stable samples already seen, so a match
  // against DB_LAST means the current sample is the last one needed.
  localparam logic [23:0] DB_LAST     = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [25:0] DELAY_LAST  = 26'(REPEAT_DELAY - 1);
  localparam logic [25:0] PERIOD_LAST = 26'(REPEAT_PERIOD - 1);
  localparam bit          REPEAT_ON   = (REPEAT_EN != 0);

  logic        sync_meta;
  logic        btn_sync;
  logic [1:0]  state;
  logic [23:0] stable_cnt;
  logic [25:0] repeat_cnt;
  logic        repeat_phase;
  logic [25:0] repeat_last;

  assign pressed     = (state == HELD) || (state == RELEASE_WAIT);
  assign repeat_last = repeat_phase ? PERIOD_LAST : DELAY_LAST;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta     <= 1'b1;
      btn_sync      <= 1'b1;
      state         <= IDLE;
      stable_cnt    <= '0;
      repeat_cnt    <= '0;
      repeat_phase  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_meta     <= button;
      btn_sync      <= sync_meta;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (!btn_sync) begin
            if (DB_LAST == '0) begin
              state       <= HELD;
              press_pulse <= 1'b1;
            end else begin
              state      <= PRESS_WAIT;
              stable_cnt <= 24'd1;
            end
          end
        end
        PRESS_WAIT: begin
          if (btn_sync) begin
            state      <= IDLE;
            stable_cnt <= '0;
          end else if (stable_cnt == DB_LAST) begin
            state        <= HELD;
            stable_cnt   <= '0;
            press_pulse  <= 1'b1;
            repeat_cnt   <= '0;
            repeat_phase <= 1'b0;
          end else begin
            stable_cnt <= stable_cnt + 24'd1;
          end
        end
        HELD: begin
          if (btn_sync) begin
            repeat_cnt   <= '0;
            repeat_phase <= 1'b0;
            if (DB_LAST == '0) begin
              state         <= IDLE;
              release_pulse <= 1'b1;
            end else begin
              state      <= RELEASE_WAIT;
              stable_cnt <= 24'd1;
            end
          end else if (REPEAT_ON) begin
            // First interval is the delay, every later one the period.
            if (repeat_cnt == repeat_last) begin
              repeat_cnt   <= '0;
              repeat_phase <= 1'b1;
              press_pulse  <= 1'b1;
            end else begin
              repeat_cnt <= repeat_cnt + 26'd1;
            end
          end
        end
        RELEASE_WAIT: begin
          if (!btn_sync) begin
            state        <= HELD;
            stable_cnt   <= '0;
            repeat_cnt   <= '0;
            repeat_phase <= 1'b0;
          end else if (stable_cnt == DB_LAST) begin
            state         <= IDLE;
            stable_cnt    <= '0;
            release_pulse <= 1'b1;
          end else begin
            stable_cnt <= stable_cnt + 24'd1;
          end
        end
        default: begin
          state      <= IDLE;
          stable_cnt <= '0;
        end
      endcase
    end
  end

endmodule
